// File: rtl/mmio_pkg.sv
// Shared MMIO router types: core/device bus records, router FSM states and
// the read data handed back when a device never answers.
package mmio_pkg;
    typedef logic [31:0] Addr;
    typedef logic [31:0] UIntX;

    typedef struct packed {
        logic       valid;
        Addr        addr;
        logic       wen;
        UIntX       wdata;
        logic [3:0] wmask;
    } DReq;

    typedef struct packed {
        logic valid;
        Addr  addr;
        UIntX rdata;
    } DResp;

    typedef enum logic [1:0] {IDLE, WAIT_READY, READ_VALID} statetype;

    localparam UIntX ERR_RDATA_DEF = 32'hDEADBEEF;

    // Width of a device index; a single device still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mmio_router_if.sv
// Bus bundle between the core, the default memory port and the device slaves.
// The router uses the slave view; whoever drives the core and devices uses master.
interface mmio_router_if #(parameter int NDEV = 3) ();
    import mmio_pkg::*;

    DReq                        dreq_in;
    logic                       dreq_ready;
    DResp                       dresp_in;
    logic                       err;
    DReq                        memreq_in;
    logic                       memreq_ready;
    DResp                       memresp_in;
    logic [NDEV-1:0]            dev_req_valid;
    logic [NDEV-1:0]            dev_req_ready;
    Addr                        dev_req_addr;
    logic                       dev_req_wen;
    UIntX                       dev_req_wdata;
    logic [3:0]                 dev_req_wmask;
    logic [NDEV-1:0]            dev_resp_valid;
    logic [NDEV-1:0][31:0]      dev_resp_rdata;

    modport slave (
        input  dreq_in, memreq_ready, memresp_in, dev_req_ready, dev_resp_valid, dev_resp_rdata,
        output dreq_ready, dresp_in, err, memreq_in, dev_req_valid, dev_req_addr,
               dev_req_wen, dev_req_wdata, dev_req_wmask
    );

    modport master (
        output dreq_in, memreq_ready, memresp_in, dev_req_ready, dev_resp_valid, dev_resp_rdata,
        input  dreq_ready, dresp_in, err, memreq_in, dev_req_valid, dev_req_addr,
               dev_req_wen, dev_req_wdata, dev_req_wmask
    );
endinterface

// File: rtl/mmio_addr_decoder.sv
// Maps an address onto the device windows: one-hot winner (lowest index on
// overlap), its index, and the offset inside its window. No hit means memory.
module mmio_addr_decoder
    import mmio_pkg::*;
#(
    parameter int                    NDEV     = 3,
    parameter logic [NDEV-1:0][31:0] DEV_BASE = '0,
    parameter logic [NDEV-1:0][31:0] DEV_SIZE = '0,
    localparam int                   IW       = idx_w(NDEV)
) (
    input  Addr             addr_i,
    output logic [NDEV-1:0] hit_o,
    output logic [IW-1:0]   idx_o,
    output logic            dev_o,
    output Addr             offset_o
);
    logic [NDEV-1:0] raw;

    for (genvar i = 0; i < NDEV; i++) begin : g_win
        assign raw[i] = (addr_i & ~(DEV_SIZE[i] - 32'd1)) == DEV_BASE[i];
    end

    // Walk downwards so the lowest matching window is the last one written.
    always_comb begin
        hit_o    = '0;
        idx_o    = '0;
        dev_o    = 1'b0;
        offset_o = addr_i;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (raw[i]) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
                idx_o    = IW'(i);
                dev_o    = 1'b1;
                offset_o = addr_i - DEV_BASE[i];
            end
        end
    end
endmodule

// File: rtl/mmio_router.sv
// Routes core MMIO requests to NDEV device windows or the memory port, one
// request in flight, with a timeout that answers for a hung device.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int                    NDEV      = 3,
    parameter logic [NDEV-1:0][31:0] DEV_BASE  = {32'hF000_1000, 32'hF000_0000, 32'hF000_0000},
    parameter logic [NDEV-1:0][31:0] DEV_SIZE  = {32'h0000_0100, 32'h0000_0010, 32'h0000_0008},
    parameter int unsigned           TIMEOUT   = 1023,
    parameter UIntX                  ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mmio_router_if.slave bus
);
    localparam int            IW   = idx_w(NDEV);
    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    statetype        state_q, state_d;
    DReq             req_q, req_d;
    logic            tdev_q, tdev_d;
    logic [IW-1:0]   tidx_q, tidx_d;
    logic [TW-1:0]   timer_q, timer_d;

    DReq             act;
    logic [NDEV-1:0] act_hit;
    logic [IW-1:0]   act_idx;
    logic            act_dev;
    Addr             act_off;
    logic            tmo, resp_ok, completion, take, issuing, tgt_ready;
    UIntX            resp_data;

    assign tmo        = timer_q == TMAX;
    assign resp_ok    = tdev_q ? bus.dev_resp_valid[tidx_q] : bus.memresp_in.valid;
    assign resp_data  = tdev_q ? bus.dev_resp_rdata[tidx_q] : bus.memresp_in.rdata;
    assign completion = (state_q == READ_VALID) && (resp_ok || tmo);
    // The core's live request goes straight out whenever the router can take it.
    assign take       = (state_q == IDLE) || completion;
    assign act        = take ? bus.dreq_in : req_q;
    assign issuing    = act.valid && ((state_q != READ_VALID) || completion);
    assign tgt_ready  = act_dev ? bus.dev_req_ready[act_idx] : bus.memreq_ready;

    mmio_addr_decoder #(
        .NDEV(NDEV), .DEV_BASE(DEV_BASE), .DEV_SIZE(DEV_SIZE)
    ) u_dec (
        .addr_i(act.addr), .hit_o(act_hit), .idx_o(act_idx), .dev_o(act_dev), .offset_o(act_off)
    );

    assign bus.dreq_ready    = take;
    assign bus.dev_req_valid = (issuing && act_dev) ? act_hit : '0;
    assign bus.dev_req_addr  = act_off;
    assign bus.dev_req_wen   = act.wen;
    assign bus.dev_req_wdata = act.wdata;
    assign bus.dev_req_wmask = act.wmask;

    always_comb begin
        bus.memreq_in       = act;
        bus.memreq_in.valid = issuing && !act_dev;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tdev_d  = tdev_q;
        tidx_d  = tidx_q;
        timer_d = (state_q != IDLE && !tmo) ? timer_q + TW'(1) : timer_q;
        bus.err               = 1'b0;
        bus.dresp_in          = '0;
        bus.dresp_in.addr     = req_q.addr;
        case (state_q)
            WAIT_READY: begin
                if (tgt_ready) begin
                    state_d = req_q.wen ? IDLE : READ_VALID;
                end else if (tmo) begin
                    state_d                = IDLE;
                    bus.err                = 1'b1;
                    bus.dresp_in.valid     = !req_q.wen;
                    bus.dresp_in.rdata     = ERR_RDATA;
                end
            end
            READ_VALID: begin
                if (resp_ok) begin
                    bus.dresp_in.valid = 1'b1;
                    bus.dresp_in.rdata = resp_data;
                end else if (tmo) begin
                    bus.dresp_in.valid = 1'b1;
                    bus.dresp_in.rdata = ERR_RDATA;
                    bus.err            = 1'b1;
                end
                if (completion) state_d = IDLE;
            end
            default: ;
        endcase
        // New request accepted in IDLE or on the read-completion cycle.
        if (take && bus.dreq_in.valid) begin
            req_d   = bus.dreq_in;
            tdev_d  = act_dev;
            tidx_d  = act_idx;
            timer_d = '0;
            state_d = tgt_ready ? (bus.dreq_in.wen ? IDLE : READ_VALID) : WAIT_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            tdev_q  <= 1'b0;
            tidx_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tdev_q  <= tdev_d;
            tidx_q  <= tidx_d;
            timer_q <= timer_d;
        end
    end
endmodule

// File: tb/tb_mmio_router.sv
// Bench for mmio_router: a table of directed cycles followed by random
// traffic scored against a transaction-level model of the router.
module tb_mmio_router;
    import mmio_pkg::*;

    localparam int                  ND   = 3;
    localparam int                  TO   = 4;
    localparam logic [ND-1:0][31:0] BASE = {32'hF000_1000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [ND-1:0][31:0] SIZE = {32'h0000_0100, 32'h0000_0010, 32'h0000_0008};
    localparam logic [31:0]         K    = 32'h1234_5678;
    localparam logic [31:0]         MEMD = 32'h3E3E_0000;
    localparam logic [31:0]         ERRD = 32'hDEADBEEF;
    localparam logic [31:0]         G    = 32'hF000_0004;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mmio_router_if #(.NDEV(ND)) bus ();

    mmio_router #(
        .NDEV(ND), .DEV_BASE(BASE), .DEV_SIZE(SIZE), .TIMEOUT(TO), .ERR_RDATA(ERRD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic rst, v, w, mrdy, mrv;
        logic [31:0] a;
        logic [2:0]  drdy, drv;
        logic [2:0]  e_dv;
        logic        e_mv, e_rdy, e_rv, e_err, e_w;
        logic [31:0] e_rd, e_da, e_fa;
    } vec_t;

    vec_t tbl[$];
    vec_t r;

    function automatic vec_t mk(
        input logic rst, v, input logic [31:0] a, input logic w,
        input logic [2:0] drdy, input logic mrdy, input logic [2:0] drv, input logic mrv,
        input logic [2:0] e_dv, input logic e_mv, e_rdy, e_rv, input logic [31:0] e_rd,
        input logic e_err, input logic [31:0] e_da, e_fa, input logic e_w);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.w = w; t.drdy = drdy; t.mrdy = mrdy;
        t.drv = drv; t.mrv = mrv; t.e_dv = e_dv; t.e_mv = e_mv; t.e_rdy = e_rdy;
        t.e_rv = e_rv; t.e_rd = e_rd; t.e_err = e_err; t.e_da = e_da; t.e_fa = e_fa;
        t.e_w = e_w;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, v, input logic [31:0] a, input logic w,
                         input logic [2:0] drdy, input logic mrdy,
                         input logic [2:0] drv, input logic mrv);
        reset                = rst;
        bus.dreq_in.valid    = v;
        bus.dreq_in.addr     = a;
        bus.dreq_in.wen      = w;
        bus.dreq_in.wdata    = a ^ K;
        bus.dreq_in.wmask    = 4'hF;
        bus.dev_req_ready    = drdy;
        bus.memreq_ready     = mrdy;
        bus.dev_resp_valid   = drv;
        bus.memresp_in.valid = mrv;
        bus.memresp_in.addr  = 32'h0;
    endtask

    // e_da: expected device offset; e_fa: expected full address of the issued request.
    task automatic check_outs(input string tag, input logic [2:0] e_dv, input logic e_mv,
                              input logic e_rdy, e_rv, input logic [31:0] e_rd, input logic e_err,
                              input logic [31:0] e_da, e_fa, input logic e_w,
                              input logic chk_ra, input logic [31:0] e_ra);
        chk({tag, ".dev_valid"}, 32'(bus.dev_req_valid), 32'(e_dv));
        chk({tag, ".mem_valid"}, 32'(bus.memreq_in.valid), 32'(e_mv));
        chk({tag, ".ready"}, 32'(bus.dreq_ready), 32'(e_rdy));
        chk({tag, ".dresp_valid"}, 32'(bus.dresp_in.valid), 32'(e_rv));
        chk({tag, ".err"}, 32'(bus.err), 32'(e_err));
        if (e_rv) chk({tag, ".rdata"}, bus.dresp_in.rdata, e_rd);
        if (e_rv && chk_ra) chk({tag, ".dresp_addr"}, bus.dresp_in.addr, e_ra);
        if (e_dv != 3'b000) begin
            chk({tag, ".dev_addr"}, bus.dev_req_addr, e_da);
            chk({tag, ".dev_wdata"}, bus.dev_req_wdata, e_fa ^ K);
            chk({tag, ".dev_wen"}, 32'(bus.dev_req_wen), 32'(e_w));
        end
        if (e_mv) begin
            chk({tag, ".mem_addr"}, bus.memreq_in.addr, e_fa);
            chk({tag, ".mem_wdata"}, bus.memreq_in.wdata, e_fa ^ K);
            chk({tag, ".mem_wen"}, 32'(bus.memreq_in.wen), 32'(e_w));
        end
    endtask

    // Window lookup by range comparison; the first listed window wins.
    function automatic int tgt_of(input logic [31:0] a);
        for (int i = 0; i < ND; i++)
            if (a >= BASE[i] && (a - BASE[i]) < SIZE[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 32'hF000_0000 + $urandom_range(0, 15);
            1: return 32'hF000_1000 + $urandom_range(0, 255);
            2: return 32'hF000_0FF0 + $urandom_range(0, 31);
            3: return 32'hF000_10F0 + $urandom_range(0, 31);
            4: return 32'hF000_0000 + $urandom_range(0, 31);
            default: return $urandom & 32'h0FFF_FFFF;
        endcase
    endfunction

    // Random-phase stimulus and model state.
    logic        rv_, rr_, rw_, rmrdy, rmrv;
    logic [2:0]  rdrdy, rdrv;
    logic [31:0] ra_, rmrd;
    logic [ND-1:0][31:0] rrd;
    bit          busy, got, finish_rd, take, tr, rvm, issue, fw;
    int          age, mt, nt;
    logic [31:0] ma, fa;
    bit          mw;
    logic [2:0]  e_dv;
    logic        e_mv, e_rv, e_err;
    logic [31:0] e_rd, e_da;

    initial begin
        drive(1'b1, 1'b0, G, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < ND; i++) bus.dev_resp_rdata[i] = 32'hD0D0_0000 | i;
        bus.memresp_in.rdata = MEMD;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        tbl.push_back(mk(1,0,G,0, 0,0,0,0, 0,0,1,0,0,0, 0,0,0));
        // dev1 read; the response offered alongside ready is too early and ignored
        tbl.push_back(mk(0,1,32'hF000_0008,0, 3'b010,0,3'b010,0, 3'b010,0,1,0,0,0, 8,32'hF000_0008,0));
        tbl.push_back(mk(0,0,G,0, 0,0,3'b010,0, 0,0,1,1,32'hD0D0_0001,0, 0,0,0));
        tbl.push_back(mk(0,0,G,0, 0,0,0,0, 0,0,1,0,0,0, 0,0,0));
        // unmapped write, memory stalls three cycles; the core bus carries junk meanwhile
        tbl.push_back(mk(0,1,32'h0000_1000,1, 0,0,0,0, 0,1,1,0,0,0, 0,32'h0000_1000,1));
        tbl.push_back(mk(0,0,G,0, 3'b111,0,0,0, 0,1,0,0,0,0, 0,32'h0000_1000,1));
        tbl.push_back(mk(0,0,G,0, 3'b111,0,0,0, 0,1,0,0,0,0, 0,32'h0000_1000,1));
        tbl.push_back(mk(0,0,G,0, 0,1,0,0, 0,1,0,0,0,0, 0,32'h0000_1000,1));
        tbl.push_back(mk(0,0,G,0, 0,0,0,0, 0,0,1,0,0,0, 0,0,0));
        // back-to-back: dev0 (overlaps dev1) then memory on the completion cycle
        tbl.push_back(mk(0,1,32'hF000_0004,0, 3'b011,0,0,0, 3'b001,0,1,0,0,0, 4,32'hF000_0004,0));
        tbl.push_back(mk(0,1,32'h0000_2000,0, 0,1,3'b001,0, 0,1,1,1,32'hD0D0_0000,0, 0,32'h0000_2000,0));
        tbl.push_back(mk(0,0,G,0, 0,0,0,1, 0,0,1,1,MEMD,0, 0,0,0));
        tbl.push_back(mk(0,0,G,0, 0,0,0,0, 0,0,1,0,0,0, 0,0,0));
        // dev2 read never answered; late answer afterwards is ignored
        tbl.push_back(mk(0,1,32'hF000_1020,0, 3'b100,0,0,0, 3'b100,0,1,0,0,0, 32'h20,32'hF000_1020,0));
        for (int i = 0; i < TO; i++)
            tbl.push_back(mk(0,0,G,0, 0,0,3'b011,1, 0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,G,0, 0,0,0,0, 0,0,1,1,ERRD,1, 0,0,0));
        tbl.push_back(mk(0,0,G,0, 0,0,3'b100,0, 0,0,1,0,0,0, 0,0,0));
        // reset while waiting for read data
        tbl.push_back(mk(0,1,32'hF000_0008,0, 3'b010,0,0,0, 3'b010,0,1,0,0,0, 8,32'hF000_0008,0));
        tbl.push_back(mk(1,0,G,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,G,0, 0,0,3'b010,0, 0,0,1,0,0,0, 0,0,0));
        // reset while the memory port stalls: strobe holds this cycle, drops the next
        tbl.push_back(mk(0,1,32'h0000_3000,1, 0,0,0,0, 0,1,1,0,0,0, 0,32'h0000_3000,1));
        tbl.push_back(mk(1,0,G,0, 0,0,0,0, 0,1,0,0,0,0, 0,32'h0000_3000,1));
        tbl.push_back(mk(0,0,G,0, 0,0,0,0, 0,0,1,0,0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            drive(r.rst, r.v, r.a, r.w, r.drdy, r.mrdy, r.drv, r.mrv);
            #3;
            check_outs($sformatf("row%0d", i), r.e_dv, r.e_mv, r.e_rdy, r.e_rv, r.e_rd,
                       r.e_err, r.e_da, r.e_fa, r.e_w, 1'b0, 32'h0);
            @(posedge clk);
            #1;
        end

        busy = 0; got = 0; age = 0; mt = -1; ma = '0; mw = 0;
        for (int c = 0; c < 3000; c++) begin
            rr_ = ($urandom_range(0, 99) == 0);
            rv_ = ($urandom_range(0, 9) < 6);
            ra_ = rand_addr();
            rw_ = $urandom_range(0, 1);
            for (int i = 0; i < ND; i++) begin
                rdrdy[i] = ($urandom_range(0, 2) == 0);
                rdrv[i]  = ($urandom_range(0, 2) == 0);
                rrd[i]   = $urandom;
            end
            rmrdy = ($urandom_range(0, 2) == 0);
            rmrv  = ($urandom_range(0, 2) == 0);
            rmrd  = $urandom;
            drive(rr_, rv_, ra_, rw_, rdrdy, rmrdy, rdrv, rmrv);
            bus.dev_resp_rdata   = rrd;
            bus.memresp_in.rdata = rmrd;

            // Expected outputs for this cycle from the outstanding transaction.
            tr  = busy && (mt < 0 ? rmrdy : rdrdy[mt]);
            rvm = busy && (mt < 0 ? rmrv : rdrv[mt]);
            finish_rd = busy && got && (rvm || age >= TO);
            take = !busy || finish_rd;
            e_dv = '0; e_mv = 0; e_rv = 0; e_err = 0; e_rd = '0; e_da = '0;
            if (busy && got) begin
                if (rvm) begin
                    e_rv = 1; e_rd = (mt < 0) ? rmrd : rrd[mt];
                end else if (age >= TO) begin
                    e_rv = 1; e_rd = ERRD; e_err = 1;
                end
            end else if (busy && !got && !tr && age >= TO) begin
                e_err = 1; e_rv = !mw; e_rd = ERRD;
            end
            issue = 0; nt = -1; fa = '0; fw = 0;
            if (take && rv_) begin
                issue = 1; nt = tgt_of(ra_); fa = ra_; fw = rw_;
            end else if (busy && !got) begin
                issue = 1; nt = mt; fa = ma; fw = mw;
            end
            if (issue) begin
                if (nt < 0) e_mv = 1;
                else begin e_dv[nt] = 1'b1; e_da = fa - BASE[nt]; end
            end
            #3;
            check_outs($sformatf("rnd%0d", c), e_dv, e_mv, take, e_rv, e_rd, e_err,
                       e_da, fa, fw, 1'b1, ma);

            // Advance the model.
            if (busy && !got) begin
                if (tr) begin
                    if (mw) busy = 0; else got = 1;
                end else if (age >= TO) busy = 0;
            end else if (finish_rd) busy = 0;
            age++;
            if (take && rv_) begin
                busy = 1; got = 0; age = 0; mt = nt; ma = ra_; mw = rw_;
                if (nt < 0 ? rmrdy : rdrdy[nt]) begin
                    if (rw_) busy = 0; else got = 1;
                end
            end
            if (rr_) busy = 0;
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
